// File: rtl/bus_timer.sv
// Memory-mapped prescaled timer with compare match, auto-reload and a level
// interrupt. Four word registers sit in a 16-byte window at BASE.
module bus_timer #(
  parameter logic [31:0] BASE = 32'h0000_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] b_addr,
  input  logic        b_we,
  input  logic [31:0] b_in,
  output logic [31:0] b_out,
  output logic        irq
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic        en, autoReload, irqEn;
  logic [7:0]  pre;
  logic [7:0]  pc;
  logic [31:0] count, compare;
  logic        match;

  logic        sel;
  logic [1:0]  regSel;
  logic        wrCtrl, wrCount, wrCmp, wrStatus;
  logic        tick, hit;
  logic [31:0] rdData;

  assign sel      = (b_addr[31:4] == BASE[31:4]);
  assign regSel   = b_addr[3:2];
  assign wrCtrl   = sel && b_we && (regSel == REG_CTRL);
  assign wrCount  = sel && b_we && (regSel == REG_COUNT);
  assign wrCmp    = sel && b_we && (regSel == REG_CMP);
  assign wrStatus = sel && b_we && (regSel == REG_STATUS);

  // Compare uses the registered COMPARE, so a same-cycle write affects only later ticks.
  assign tick = en && (pc == pre);
  assign hit  = tick && (count == compare);

  always_comb begin
    rdData = 32'd0;
    case (regSel)
      REG_CTRL:   rdData = {16'd0, pre, 5'd0, irqEn, autoReload, en};
      REG_COUNT:  rdData = count;
      REG_CMP:    rdData = compare;
      REG_STATUS: rdData = {31'd0, match};
      default:    rdData = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en         <= 1'b0;
      autoReload <= 1'b0;
      irqEn      <= 1'b0;
      pre        <= 8'd0;
      pc         <= 8'd0;
      count      <= 32'd0;
      compare    <= 32'd0;
      match      <= 1'b0;
      b_out      <= 32'd0;
      irq        <= 1'b0;
    end else begin
      b_out <= sel ? rdData : 32'd0;
      irq   <= match & irqEn;

      if (wrCtrl) begin
        en         <= b_in[0];
        autoReload <= b_in[1];
        irqEn      <= b_in[2];
        pre        <= b_in[15:8];
      end

      if (!en || wrCtrl || tick) pc <= 8'd0;
      else                       pc <= pc + 8'd1;

      // CPU write to COUNT overrides the tick update.
      if (wrCount)   count <= b_in;
      else if (tick) count <= (hit && autoReload) ? 32'd0 : count + 32'd1;

      if (wrCmp) compare <= b_in;

      // A match in the same cycle as a clear leaves MATCH set.
      if (hit)                      match <= 1'b1;
      else if (wrStatus && b_in[0]) match <= 1'b0;
    end
  end

endmodule
